pid_seq: RTL and testbench
==========================

# pid_seq

Multi-channel fixed-point discrete PID controller with a built-in channel sequencer. It is the next generation of the single-address PID block: one `start` pulse sweeps all 2^AW channels back to back. Each channel has its own coefficient registers, enable bit and saturation flag. The block sits between the error sources (encoder/setpoint subtractors, selected through `error_addr`) and the PWM generators (read through `rd_addr`/`m_out`), and is configured by the CPU through a write port.

## Interface
- AW, 1: channel address width; channel count N = 2^AW
- EW, 24: error input width, signed; EW < PW
- OW, 12: output width, signed
- PW, 32: accumulator width
- CW, 6: coefficient width, signed shift exponent
- FP, 9: log2 of the control loop frequency
- PRECISION, 1: fractional bits of the accumulator
- ANTIWINDUP, 32'hFF<<(PRECISION+OW-9): accumulator clamp limit; must be < 2^(PRECISION+OW-1)
- clk_pid  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request to sweep all channels
- error_addr  out  AW  registered; the channel whose error is requested
- error_in  in  EW  signed error of channel `error_addr`
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at the end of a sweep
- cfg_we  in  1  configuration write strobe
- cfg_addr  in  AW  channel being configured
- cfg_kp, cfg_ki, cfg_kd  in  CW each  signed exponents, -31..31
- cfg_en  in  1  channel enable written with the coefficients
- cfg_clr  in  1  with cfg_we: clear the channel state
- rd_addr  in  AW  output read select
- m_out  out  OW  combinational read of m[rd_addr]
- rd_sat  out  1  combinational read of sat[rd_addr]

## Operation
- Per-channel state: u (PW bits), e0, e1, e2 (PW bits, sign-extended), m (OW bits), sat, en, kp, ki, kd.
- Velocity form of the update, applied in order:
  - P: u += (e0<<<p) − (e1<<<p)
  - D: u += (e0<<<d) + (e2<<<d)
  - I: u += (e0<<<i) + (e1<<<i)
  - D2: u −= (e1<<<d2)
- Effective exponents are computed in CW+2 bits, so they never wrap:
  - p = kp+PRECISION
  - d = kd+PRECISION+FP
  - i = ki+PRECISION−1−FP
  - d2 = kd+PRECISION+1+FP
- Shift rules:
  - Non-negative exponent: arithmetic left shift.
  - Negative exponent: arithmetic right shift by its magnitude.
  - A left shift ≥ PW gives 0; a right shift ≥ PW gives the sign fill (0 or −1).
- Sums wrap modulo 2^PW.
- Clamp:
  - If u > ANTIWINDUP, u is set to ANTIWINDUP; if u < −ANTIWINDUP, u is set to −ANTIWINDUP.
  - sat is set to 1 when a clamp occurs and to 0 otherwise.
- Output: m = u[PRECISION+OW−1:PRECISION].
- State machine:
  - IDLE → FETCH (ch=0) on start.
  - FETCH: if en[ch]=0, go to the next channel; otherwise latch e0 = sext(error_in) and snapshot the channel coefficients, then go to P.
  - Then P → D → I → D2 → CLAMP → COMMIT.
  - COMMIT: write m, shift e2←e1 and e1←e0, then go to the next channel.
  - Next channel: FETCH with ch+1, or DONE after channel N−1.
  - DONE → IDLE.
- start is ignored while busy=1.
- cfg writes:
  - Coefficient and enable writes are accepted at any time. A channel mid-computation keeps its snapshot, so a new value takes effect at that channel's next FETCH.
  - cfg_clr, or a write with cfg_en=0, zeroes u, e1, e2, m and sat of the channel. This is honoured only when busy=0 and ignored when busy=1; coefficient writes in the same beat still apply.
- A disabled channel reads m=0 and rd_sat=0.

## Timing
- Reset state:
  - state IDLE, busy=0, done=0, error_addr=0.
  - For all channels: u, e*, m, sat, en, kp, ki and kd are 0.
- start sampled high in IDLE: busy=1 from the next cycle.
- error_addr = ch during FETCH; error_in must be valid in that cycle and is sampled at its end.
- Per channel: 7 cycles when enabled, 1 cycle when disabled. m is updated at the end of COMMIT.
- DONE cycle: done=1 and busy=1. busy=0 in the following cycle.
- Sweep length in cycles = 7·(enabled) + (disabled) + 1.
- Reset asserted mid-sweep: state returns to IDLE and all registers go to their reset values immediately. No done pulse is generated.
- A start pulse in the DONE cycle is ignored. A start pulse in the first IDLE cycle after DONE is accepted.

## Test plan
Defaults for all scenarios: AW=1, PW=32, OW=12, PRECISION=1, FP=9, ANTIWINDUP=4080.

1. P-only response:
   - Stimulus: ch0 with kp=2, ki=−31, kd=−31, en=1; error_in=10 held; two sweeps.
   - Required: u=80 and m_out=40 after sweep 1; u=80 and m_out=40 after sweep 2.
2. Anti-windup:
   - Stimulus: ch0 with kp=10 (others −31); error 100, then −100.
   - Required: after the first sweep u=4080, m=2040, rd_sat=1; after the second sweep u=−4080, m=−2040, rd_sat=1.
3. Sweep timing:
   - Stimulus: both channels enabled; pulse start.
   - Required: busy high for exactly 15 cycles; error_addr=0 then 1 in the FETCH cycles; a single done pulse in cycle 15.
4. Disabled channel:
   - Stimulus: ch1 en=0.
   - Required: sweep is 9 cycles; ch1 m_out=0; ch1 error_in is never consumed.
5. Ignored requests while busy:
   - Stimulus: start re-pulsed mid-sweep, and cfg_clr on ch0 while busy.
   - Required: no extra sweep; ch0 state unchanged. The same cfg_clr while idle zeroes m_out and rd_sat.
6. Reset mid-sweep:
   - Stimulus: assert reset during the D state of ch0.
   - Required: busy=0 and done=0 immediately; all m_out=0; the next start performs a full sweep from zero state.

Source files
------------

// File: rtl/pid_seq_if.sv
// pid_seq_if: sweep handshake, error fetch, configuration write and output read bundle.
interface pid_seq_if #(
   parameter int AW = 1,
   parameter int EW = 24,
   parameter int OW = 12,
   parameter int CW = 6
) ();
   logic                 start;
   logic                 busy;
   logic                 done;
   logic [AW-1:0]        error_addr;
   logic signed [EW-1:0] error_in;
   logic                 cfg_we;
   logic [AW-1:0]        cfg_addr;
   logic signed [CW-1:0] cfg_kp;
   logic signed [CW-1:0] cfg_ki;
   logic signed [CW-1:0] cfg_kd;
   logic                 cfg_en;
   logic                 cfg_clr;
   logic [AW-1:0]        rd_addr;
   logic signed [OW-1:0] m_out;
   logic                 rd_sat;

   // Controller side: CPU, error sources and PWM readers
   modport master (
      output start, error_in, cfg_we, cfg_addr, cfg_kp, cfg_ki, cfg_kd,
             cfg_en, cfg_clr, rd_addr,
      input  busy, done, error_addr, m_out, rd_sat
   );

   // PID sequencer side
   modport slave (
      input  start, error_in, cfg_we, cfg_addr, cfg_kp, cfg_ki, cfg_kd,
             cfg_en, cfg_clr, rd_addr,
      output busy, done, error_addr, m_out, rd_sat
   );
endinterface

// File: rtl/pid_seq.sv
// pid_seq: multi-channel velocity-form PID with a sequencer that sweeps all
// channels on one start pulse. Gains are power-of-two shift exponents.
module pid_seq #(
   parameter int AW         = 1,
   parameter int EW         = 24,
   parameter int OW         = 12,
   parameter int PW         = 32,
   parameter int CW         = 6,
   parameter int FP         = 9,
   parameter int PRECISION  = 1,
   parameter int ANTIWINDUP = 32'hFF << (PRECISION + OW - 9)
) (
   input  logic     clk_pid,
   input  logic     reset,
   pid_seq_if.slave bus
);
   localparam int N = 1 << AW;
   localparam logic [AW-1:0]        CH_LAST = AW'(N - 1);
   localparam logic [AW-1:0]        CH_ONE  = AW'(1);
   // Exponent offsets, held in CW+2 bits so the sums cannot wrap
   localparam logic signed [CW+1:0] OFS_P   = (CW+2)'(PRECISION);
   localparam logic signed [CW+1:0] OFS_D   = (CW+2)'(PRECISION + FP);
   localparam logic signed [CW+1:0] OFS_I   = (CW+2)'(PRECISION - 1 - FP);
   localparam logic signed [CW+1:0] OFS_D2  = (CW+2)'(PRECISION + 1 + FP);
   localparam logic [CW+1:0]        SH_LIM  = (CW+2)'(PW);
   localparam logic signed [PW-1:0] LIM_POS = PW'(ANTIWINDUP);
   localparam logic signed [PW-1:0] LIM_NEG = -LIM_POS;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0, ST_FETCH = 4'd1, ST_P     = 4'd2,
      ST_D      = 4'd3, ST_I     = 4'd4, ST_D2    = 4'd5,
      ST_CLAMP  = 4'd6, ST_COMMIT = 4'd7, ST_DONE = 4'd8
   } state_t;

   // Signed shift: left for non-negative exponents, arithmetic right otherwise;
   // shifts of PW or more saturate to zero / sign fill.
   function automatic logic signed [PW-1:0] ashift(input logic signed [PW-1:0] v,
                                                   input logic signed [CW+1:0] e);
      logic [CW+1:0]        mag;
      logic signed [PW-1:0] r;
      if (e[CW+1] == 1'b0) begin
         mag = e;
         if (mag >= SH_LIM) r = '0;
         else               r = v <<< mag;
      end else begin
         mag = -e;
         if (mag >= SH_LIM) r = {PW{v[PW-1]}};
         else               r = v >>> mag;
      end
      return r;
   endfunction

   state_t          state_q, state_d;
   logic [AW-1:0]   ch_q, ch_d;
   logic            busy_q, done_q;

   logic signed [PW-1:0] acc_q, acc_d;
   logic signed [PW-1:0] e0_q, e0_d;
   logic                 sat_w_q, sat_w_d;
   logic signed [CW-1:0] kp_w_q, ki_w_q, kd_w_q;
   logic                 load_s, commit_s;

   logic signed [PW-1:0] u_q   [N];
   logic signed [PW-1:0] e1_q  [N];
   logic signed [PW-1:0] e2_q  [N];
   logic signed [OW-1:0] m_q   [N];
   logic                 sat_q [N];
   logic                 en_q  [N];
   logic signed [CW-1:0] kp_q  [N];
   logic signed [CW-1:0] ki_q  [N];
   logic signed [CW-1:0] kd_q  [N];

   logic signed [CW+1:0] p_s, d_s, i_s, d2_s;
   logic signed [PW-1:0] e1_cur_s, e2_cur_s;

   assign p_s  = {{2{kp_w_q[CW-1]}}, kp_w_q} + OFS_P;
   assign d_s  = {{2{kd_w_q[CW-1]}}, kd_w_q} + OFS_D;
   assign i_s  = {{2{ki_w_q[CW-1]}}, ki_w_q} + OFS_I;
   assign d2_s = {{2{kd_w_q[CW-1]}}, kd_w_q} + OFS_D2;
   assign e1_cur_s = e1_q[ch_q];
   assign e2_cur_s = e2_q[ch_q];

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.error_addr = ch_q;

   // Sequencer state register with registered busy/done flags
   always_ff @(posedge clk_pid or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         ch_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         busy_q  <= (state_d != ST_IDLE);
         done_q  <= (state_d == ST_DONE);
      end
   end

   // Next-state: walk the pipeline per channel, skipping disabled ones
   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = ST_FETCH;
               ch_d    = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FETCH: begin
            if (en_q[ch_q])            state_d = ST_P;
            else if (ch_q == CH_LAST)  state_d = ST_DONE;
            else                       ch_d    = ch_q + CH_ONE;
         end
         ST_P:     state_d = ST_D;
         ST_D:     state_d = ST_I;
         ST_I:     state_d = ST_D2;
         ST_D2:    state_d = ST_CLAMP;
         ST_CLAMP: state_d = ST_COMMIT;
         ST_COMMIT: begin
            if (ch_q == CH_LAST) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_FETCH;
               ch_d    = ch_q + CH_ONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            ch_d    = '0;
         end
         default: begin
            state_d = ST_IDLE;
            ch_d    = '0;
         end
      endcase
   end

   // Datapath controls: one accumulate step per state, clamp, then commit
   always_comb begin
      acc_d    = acc_q;
      e0_d     = e0_q;
      sat_w_d  = sat_w_q;
      load_s   = 1'b0;
      commit_s = 1'b0;
      case (state_q)
         ST_FETCH: begin
            if (en_q[ch_q]) begin
               load_s = 1'b1;
               acc_d  = u_q[ch_q];
               e0_d   = {{(PW-EW){bus.error_in[EW-1]}}, bus.error_in};
            end else begin
               load_s = 1'b0;
            end
         end
         ST_P:  acc_d = acc_q + ashift(e0_q, p_s) - ashift(e1_cur_s, p_s);
         ST_D:  acc_d = acc_q + ashift(e0_q, d_s) + ashift(e2_cur_s, d_s);
         ST_I:  acc_d = acc_q + ashift(e0_q, i_s) + ashift(e1_cur_s, i_s);
         ST_D2: acc_d = acc_q - ashift(e1_cur_s, d2_s);
         ST_CLAMP: begin
            if (acc_q > LIM_POS) begin
               acc_d   = LIM_POS;
               sat_w_d = 1'b1;
            end else if (acc_q < LIM_NEG) begin
               acc_d   = LIM_NEG;
               sat_w_d = 1'b1;
            end else begin
               sat_w_d = 1'b0;
            end
         end
         ST_COMMIT: commit_s = 1'b1;
         default: begin
            acc_d = acc_q;
         end
      endcase
   end

   // Working registers for the channel under computation, incl. coefficient snapshot
   always_ff @(posedge clk_pid or posedge reset) begin
      if (reset) begin
         acc_q   <= '0;
         e0_q    <= '0;
         sat_w_q <= 1'b0;
         kp_w_q  <= '0;
         ki_w_q  <= '0;
         kd_w_q  <= '0;
      end else begin
         acc_q   <= acc_d;
         e0_q    <= e0_d;
         sat_w_q <= sat_w_d;
         if (load_s) begin
            kp_w_q <= kp_q[ch_q];
            ki_w_q <= ki_q[ch_q];
            kd_w_q <= kd_q[ch_q];
         end
      end
   end

   // Per-channel state: CPU configuration writes, idle-only clears, and commits
   always_ff @(posedge clk_pid or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < N; k++) begin
            u_q[k]   <= '0;
            e1_q[k]  <= '0;
            e2_q[k]  <= '0;
            m_q[k]   <= '0;
            sat_q[k] <= 1'b0;
            en_q[k]  <= 1'b0;
            kp_q[k]  <= '0;
            ki_q[k]  <= '0;
            kd_q[k]  <= '0;
         end
      end else begin
         for (int k = 0; k < N; k++) begin
            if (bus.cfg_we && (bus.cfg_addr == AW'(k))) begin
               kp_q[k] <= bus.cfg_kp;
               ki_q[k] <= bus.cfg_ki;
               kd_q[k] <= bus.cfg_kd;
               en_q[k] <= bus.cfg_en;
               if (!busy_q && (bus.cfg_clr || !bus.cfg_en)) begin
                  u_q[k]   <= '0;
                  e1_q[k]  <= '0;
                  e2_q[k]  <= '0;
                  m_q[k]   <= '0;
                  sat_q[k] <= 1'b0;
               end
            end
            if (commit_s && (ch_q == AW'(k))) begin
               u_q[k]   <= acc_q;
               e1_q[k]  <= e0_q;
               e2_q[k]  <= e1_q[k];
               m_q[k]   <= acc_q[PRECISION+OW-1:PRECISION];
               sat_q[k] <= sat_w_q;
            end
         end
      end
   end

   // Output read port; disabled channels read as zero
   always_comb begin
      if (en_q[bus.rd_addr]) begin
         bus.m_out  = m_q[bus.rd_addr];
         bus.rd_sat = sat_q[bus.rd_addr];
      end else begin
         bus.m_out  = '0;
         bus.rd_sat = 1'b0;
      end
   end
endmodule

// File: tb/tb_pid_seq.sv
// tb_pid_seq: directed bench for pid_seq with hand-computed expectations.
module tb_pid_seq;
   localparam int AW = 1;
   localparam int EW = 24;
   localparam int OW = 12;
   localparam int CW = 6;

   logic clk_pid = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   logic signed [EW-1:0] err_v [0:1];
   logic [AW-1:0]        addr_log [0:31];
   int                   sw_len;
   int                   sw_done_cnt;
   int                   sw_done_at;
   logic signed [OW-1:0] rm;
   logic                 rs;

   pid_seq_if #(.AW(AW), .EW(EW), .OW(OW), .CW(CW)) bus ();

   pid_seq dut (
      .clk_pid (clk_pid),
      .reset   (reset),
      .bus     (bus)
   );

   always #5 clk_pid = ~clk_pid;

   assign bus.error_in = err_v[bus.error_addr];

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cfg(input logic [AW-1:0] a, input logic signed [CW-1:0] kp,
                      input logic signed [CW-1:0] ki, input logic signed [CW-1:0] kd,
                      input logic en, input logic clr);
      bus.cfg_addr = a;
      bus.cfg_kp   = kp;
      bus.cfg_ki   = ki;
      bus.cfg_kd   = kd;
      bus.cfg_en   = en;
      bus.cfg_clr  = clr;
      bus.cfg_we   = 1'b1;
      @(negedge clk_pid);
      bus.cfg_we   = 1'b0;
      bus.cfg_clr  = 1'b0;
   endtask

   task automatic read_ch(input logic [AW-1:0] a);
      bus.rd_addr = a;
      #1;
      rm = bus.m_out;
      rs = bus.rd_sat;
   endtask

   // One sweep; optional extra start pulses and a cfg_clr of ch0 at given busy cycles
   task automatic run_sweep(input int restart_a, input int restart_b, input int clr_at);
      int n;
      bus.start = 1'b1;
      @(negedge clk_pid);
      bus.start   = 1'b0;
      n           = 0;
      sw_done_cnt = 0;
      sw_done_at  = 0;
      while (bus.busy === 1'b1 && n < 64) begin
         n++;
         if (n < 32) addr_log[n] = bus.error_addr;
         if (bus.done === 1'b1) begin
            sw_done_cnt++;
            sw_done_at = n;
         end
         bus.start = (n == restart_a) || (n == restart_b);
         if (n == clr_at) begin
            bus.cfg_addr = 1'b0;
            bus.cfg_kp   = 6'sd2;
            bus.cfg_ki   = -6'sd31;
            bus.cfg_kd   = -6'sd31;
            bus.cfg_en   = 1'b1;
            bus.cfg_clr  = 1'b1;
            bus.cfg_we   = 1'b1;
         end else begin
            bus.cfg_we  = 1'b0;
            bus.cfg_clr = 1'b0;
         end
         @(negedge clk_pid);
      end
      bus.start   = 1'b0;
      bus.cfg_we  = 1'b0;
      bus.cfg_clr = 1'b0;
      sw_len      = n;
   endtask

   initial begin
      reset        = 1'b1;
      bus.start    = 1'b0;
      bus.cfg_we   = 1'b0;
      bus.cfg_addr = 1'b0;
      bus.cfg_kp   = 6'sd0;
      bus.cfg_ki   = 6'sd0;
      bus.cfg_kd   = 6'sd0;
      bus.cfg_en   = 1'b0;
      bus.cfg_clr  = 1'b0;
      bus.rd_addr  = 1'b0;
      err_v[0]     = 24'sd0;
      err_v[1]     = 24'sd0;
      repeat (3) @(negedge clk_pid);
      reset = 1'b0;
      @(negedge clk_pid);

      // Reset state
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_error_addr", bus.error_addr, 0);
      read_ch(1'b0);
      check("rst_m0", rm, 0);
      check("rst_sat0", rs, 0);

      // P-only response, ch1 disabled
      cfg(1'b0, 6'sd2, -6'sd31, -6'sd31, 1'b1, 1'b0);
      err_v[0] = 24'sd10;
      err_v[1] = 24'sd500;
      run_sweep(0, 0, 0);
      check("p_sweep1_len", sw_len, 9);
      read_ch(1'b0);
      check("p_sweep1_m0", rm, 40);
      check("p_sweep1_sat0", rs, 0);
      run_sweep(0, 0, 0);
      check("p_sweep2_len", sw_len, 9);
      read_ch(1'b0);
      check("p_sweep2_m0", rm, 40);
      read_ch(1'b1);
      check("dis_m1", rm, 0);

      // Anti-windup both directions, then an idle clear
      cfg(1'b0, 6'sd10, -6'sd31, -6'sd31, 1'b1, 1'b1);
      err_v[0] = 24'sd100;
      run_sweep(0, 0, 0);
      read_ch(1'b0);
      check("aw_pos_m0", rm, 2040);
      check("aw_pos_sat0", rs, 1);
      err_v[0] = -24'sd100;
      run_sweep(0, 0, 0);
      read_ch(1'b0);
      check("aw_neg_m0", rm, -2040);
      check("aw_neg_sat0", rs, 1);
      cfg(1'b0, 6'sd10, -6'sd31, -6'sd31, 1'b1, 1'b1);
      read_ch(1'b0);
      check("idle_clr_m0", rm, 0);
      check("idle_clr_sat0", rs, 0);

      // Sweep timing with both channels enabled
      cfg(1'b0, 6'sd2, -6'sd31, -6'sd31, 1'b1, 1'b1);
      cfg(1'b1, 6'sd2, -6'sd31, -6'sd31, 1'b1, 1'b1);
      err_v[0] = 24'sd10;
      err_v[1] = -24'sd6;
      run_sweep(0, 0, 0);
      check("two_len", sw_len, 15);
      check("two_done_cnt", sw_done_cnt, 1);
      check("two_done_at", sw_done_at, 15);
      check("two_fetch_addr0", addr_log[1], 0);
      check("two_fetch_addr1", addr_log[8], 1);
      read_ch(1'b0);
      check("two_m0", rm, 40);
      read_ch(1'b1);
      check("two_m1", rm, -25);

      // Requests while busy: restart mid-sweep and in DONE, cfg_clr of ch0 while busy
      err_v[0] = 24'sd20;
      run_sweep(3, 15, 9);
      check("busy_req_len", sw_len, 15);
      check("busy_req_done_cnt", sw_done_cnt, 1);
      repeat (2) @(negedge clk_pid);
      check("busy_req_no_resweep", bus.busy, 0);
      read_ch(1'b0);
      check("busy_clr_m0", rm, 80);
      read_ch(1'b1);
      check("busy_m1", rm, -26);

      // Reset during ch0 D state
      err_v[0] = 24'sd30;
      bus.start = 1'b1;
      @(negedge clk_pid);
      bus.start = 1'b0;
      @(negedge clk_pid);
      @(negedge clk_pid);
      reset = 1'b1;
      #1;
      check("midrst_busy", bus.busy, 0);
      check("midrst_done", bus.done, 0);
      read_ch(1'b0);
      check("midrst_m0", rm, 0);
      read_ch(1'b1);
      check("midrst_m1", rm, 0);
      @(negedge clk_pid);
      reset = 1'b0;
      repeat (3) @(negedge clk_pid);
      check("midrst_after_busy", bus.busy, 0);
      check("midrst_after_done", bus.done, 0);
      cfg(1'b0, 6'sd3, -6'sd31, -6'sd31, 1'b1, 1'b0);
      cfg(1'b1, 6'sd3, -6'sd31, -6'sd31, 1'b1, 1'b0);
      run_sweep(0, 0, 0);
      check("postrst_len", sw_len, 15);
      read_ch(1'b0);
      check("postrst_m0", rm, 240);
      read_ch(1'b1);
      check("postrst_m1", rm, -49);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
